// File: rtl/sha_msg_sched.sv
// SHA-2 message-schedule generator: loads 16 message words, then streams W[0..ROUNDS-1]
// through a registered valid/ready output. MODE selects SHA-256 (0) or SHA-512 (1).
module sha_msg_sched #(
    parameter  int MODE   = 0,
    localparam int WORD_W = (MODE == 1) ? 64 : 32,
    localparam int ROUNDS = (MODE == 1) ? 80 : 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WORD_W-1:0] D_IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WORD_W-1:0] D_OUT,
    output logic [6:0]        T_OUT,
    output logic              LAST,
    output logic              BUSY
);

    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("sha_msg_sched: MODE must be 0 (SHA-256) or 1 (SHA-512)");
    end

    localparam int unsigned S0_R1 = (MODE == 1) ? 1  : 7;
    localparam int unsigned S0_R2 = (MODE == 1) ? 8  : 18;
    localparam int unsigned S0_SH = (MODE == 1) ? 7  : 3;
    localparam int unsigned S1_R1 = (MODE == 1) ? 19 : 17;
    localparam int unsigned S1_R2 = (MODE == 1) ? 61 : 19;
    localparam int unsigned S1_SH = (MODE == 1) ? 6  : 10;

    localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);
    localparam logic [6:0] T_MSG  = 7'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    state_e            state_q, state_d;
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [6:0]        tout_q, tout_d;
    logic              ovalid_q, ovalid_d;

    logic              slot_free;
    logic              loading;
    logic              produce;
    logic [WORD_W-1:0] new_word;

    assign slot_free = !ovalid_q || OUT_READY;
    assign loading   = (t_q < T_MSG);
    assign produce   = (state_q == RUN) && slot_free && (!loading || IN_VALID);
    // Window taps: win[14]=W[t-2], win[9]=W[t-7], win[1]=W[t-15], win[0]=W[t-16]
    assign new_word  = loading ? D_IN
                               : sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        win_d    = win_q;
        dout_d   = dout_q;
        tout_d   = tout_q;
        ovalid_d = ovalid_q;

        if (ovalid_q && OUT_READY) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = RUN;
                    t_d     = '0;
                end
            end
            RUN: begin
                if (produce) begin
                    dout_d   = new_word;
                    tout_d   = t_q;
                    ovalid_d = 1'b1;
                    for (int unsigned i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = new_word;
                    t_d       = t_q + 7'd1;
                    if (t_q == T_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ovalid_q && OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            t_q      <= '0;
            win_q    <= '{default: '0};
            dout_q   <= '0;
            tout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            win_q    <= win_d;
            dout_q   <= dout_d;
            tout_q   <= tout_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign IN_READY  = (state_q == RUN) && loading && slot_free;
    assign OUT_VALID = ovalid_q;
    assign D_OUT     = dout_q;
    assign T_OUT     = tout_q;
    assign LAST      = ovalid_q && (tout_q == T_LAST);
    assign BUSY      = (state_q != IDLE);

endmodule

// File: doc/sha_msg_sched.md
# sha_msg_sched

Parametrised SHA-2 message-schedule generator: the successor to the fixed 32-bit W-memory window. It accepts the 16 message words of one block over a valid/ready input, then streams the full schedule W[0..ROUNDS-1] over a valid/ready output to the compression round logic. It supports SHA-256 (32-bit, 64 rounds) and SHA-512 (64-bit, 80 rounds), and applies full backpressure on both sides.

## Interface
- MODE, 0: 0 = SHA-256 (WORD_W=32, ROUNDS=64); 1 = SHA-512 (WORD_W=64, ROUNDS=80). Any other value is a compile-time error.
- WORD_W, derived (32/64): word width. Not user-overridable.
- ROUNDS, derived (64/80): schedule length.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a new block; sampled only in IDLE.
- IN_VALID  in  1  D_IN holds a message word.
- IN_READY  out  1  block accepts D_IN this cycle.
- D_IN  in  WORD_W  message word, W[0] first.
- OUT_VALID  out  1  D_OUT/T_OUT hold schedule word W[T_OUT].
- OUT_READY  in  1  consumer takes D_OUT this cycle.
- D_OUT  out  WORD_W  registered schedule word.
- T_OUT  out  7  index of the word on D_OUT (0..ROUNDS-1).
- LAST  out  1  high with OUT_VALID when T_OUT = ROUNDS-1.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- State machine: IDLE -> RUN on START. RUN -> DRAIN when word ROUNDS-1 is produced. DRAIN -> IDLE when that word is consumed (OUT_VALID & OUT_READY).
- START is ignored outside IDLE.
- Internal state:
  - 7-bit produce counter t, cleared on entry to RUN.
  - 16-entry shift window win[0..15] of WORD_W bits; win[15] holds the newest word.
  - Output register with a valid flag.
- The slot is free when !OUT_VALID | OUT_READY.
- Produce condition in RUN:
  - t<16: slot free & IN_VALID.
  - t>=16: slot free.
- On produce:
  - Load the new word into D_OUT and set T_OUT=t and OUT_VALID=1.
  - Shift the window (win[i] <= win[i+1], win[15] <= new word).
  - Increment t.
- For t<16, the new word is D_IN.
- For t>=16, the new word is s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^WORD_W; carries are discarded.
- Sigma functions, MODE 0: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
- Sigma functions, MODE 1: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- IN_READY = (state==RUN) & (t<16) & slot free. It is combinational and does not depend on IN_VALID.
- When the output is consumed and nothing is produced in the same cycle, OUT_VALID clears.
- Simultaneous consume and produce: D_OUT is replaced in the same edge, so there is no bubble.
- The window and t are frozen whenever no produce occurs (backpressure or input stall).
- Reset (RST_N low, any time, including mid-block) has immediate effect:
  - State = IDLE; t = 0; window = 0.
  - D_OUT = 0, T_OUT = 0; OUT_VALID, LAST, IN_READY and BUSY all 0.
  - The block in progress is discarded.

## Timing
- START is sampled at edge 0. BUSY and RUN are visible after that edge. IN_READY can be high in the cycle following edge 0.
- Latency: a word accepted (IN_VALID & IN_READY) at edge k appears on D_OUT with OUT_VALID at k+1.
- Throughput: one word per cycle when IN_VALID and OUT_READY are held high. W[0] is valid after edge 1, and W[ROUNDS-1] after edge ROUNDS.
- With both handshakes held high, the block returns to IDLE after edge ROUNDS+1, and BUSY drops in that cycle. A new START is accepted in that same cycle.
- Under OUT_READY low, D_OUT, T_OUT and LAST hold stable, and OUT_VALID stays high until consumed.
- LAST is high for exactly the cycles in which W[ROUNDS-1] is presented.

## Test plan
- MODE 0, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), streaming -> W16=0x61626380, W17=0x000F0000, T_OUT steps 0..63, LAST high only at T_OUT=63, 64 output words total.
- MODE 1, W0=1, rest 0 -> W16=0x0000000000000001, W17=0, W18=0x0000200000000008; LAST only at T_OUT=79.
- MODE 0, OUT_READY low for 3 cycles while T_OUT=20 -> D_OUT/T_OUT unchanged for 3 cycles, no word lost or duplicated, and the sequence matches the streaming run.
- IN_VALID gaps during loading (deassert 2 cycles after word 5) -> IN_READY stays high, no output for those cycles, and the final schedule is identical to the no-gap run.
- START pulsed during RUN -> ignored; word count is still exactly ROUNDS.
- RST_N low while T_OUT=30 -> all outputs 0 and state IDLE immediately; a fresh START plus the "abc" block reproduces the golden W16/W17.
